// File: rtl/filter_window_ctrl.sv
// filter_window_ctrl
//   Raster-scan controller for a KxK sliding-window filter. Tracks the
//   column/row of the last accepted pixel, strobes the line-buffer advance,
//   and flags when a complete window sits at the datapath output.
//
//   Optional feature macro: FILTER_WINDOW_CTRL_RESYNC_EN
//     When defined, in_sof seen mid-frame restarts the frame and pulses
//     sof_err for one cycle (the sof_err port exists only in that build).
//
//   Ports
//     clk          in   single clock, rising edge
//     reset        in   asynchronous, active-high
//     in_valid     in   upstream pixel available
//     in_sof       in   start-of-frame marker, qualified by in_valid
//     in_ready     out  pixel accepted this cycle when in_valid is high
//     shift_en     out  line-buffer/window advance strobe (= accept)
//     out_ready    in   downstream accepts the current window
//     win_valid    out  full KxK window present at datapath output
//     col          out  column of the last accepted pixel
//     row          out  row of the last accepted pixel
//     frame_done   out  one-cycle pulse after the last pixel of a frame
//     busy         out  high whenever the FSM is not idle
//     sof_err      out  (RESYNC_EN only) mid-frame in_sof restart pulse
//
//   state  | meaning
//   IDLE   | waiting for an accepted pixel carrying in_sof
//   STREAM | counting pixels of the current frame
//   DONE   | single cycle after the last pixel, frame_done high
module filter_window_ctrl #(
    parameter int  IMAGE_WIDTH  = 640,
    parameter int  IMAGE_HEIGHT = 480,
    parameter int  KERNEL_SIZE  = 3,
    localparam int CW = $clog2(IMAGE_WIDTH),
    localparam int RW = $clog2(IMAGE_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    output logic          shift_en,
    input  logic          out_ready,
    output logic          win_valid,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          frame_done,
    output logic          busy
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
    ,
    output logic          sof_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_KMIN = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_KMIN = RW'(KERNEL_SIZE - 1);

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          win_valid_q;
    logic          frame_done_q;
    logic          busy_q;

    logic          accept;
    logic          col_wrap;
    logic [CW-1:0] col_d;
    logic [RW-1:0] row_d;
    logic          frame_end;
    logic          win_hit;
    logic          resync;

    // A held window blocks new pixels unless it is consumed in the same cycle,
    // which gives back-to-back throughput with no bubble.
    assign in_ready = (state_q != S_DONE) && (!win_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign shift_en = accept;

    always_comb begin
        col_wrap  = (col_q == COL_LAST);
        col_d     = col_wrap ? '0 : col_q + CW'(1);
        row_d     = col_wrap ? row_q + RW'(1) : row_q;
        frame_end = (row_d == ROW_LAST) && (col_d == COL_LAST);
        win_hit   = (row_d >= ROW_KMIN) && (col_d >= COL_KMIN);
    end

`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
    logic sof_err_q;
    assign resync  = accept && in_sof && (state_q == S_STREAM);
    assign sof_err = sof_err_q;
`else
    assign resync  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
            sof_err_q    <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
            sof_err_q    <= 1'b0;
`endif
            // A window is consumed whenever out_ready is high; a qualifying
            // accept below re-arms it on the same edge.
            if (out_ready) begin
                win_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    // Pixels without in_sof are shifted out but not counted.
                    if (accept && in_sof) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (resync) begin
                        col_q       <= '0;
                        row_q       <= '0;
                        win_valid_q <= 1'b0;
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
                        sof_err_q   <= 1'b1;
`endif
                    end else if (accept) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        if (win_hit) begin
                            win_valid_q <= 1'b1;
                        end
                        if (frame_end) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign win_valid  = win_valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_filter_window_ctrl.sv
module tb_filter_window_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
    localparam int NPIX = W * H;
    localparam int NWIN = (W - K + 1) * (H - K + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          shift_en;
    logic          win_valid;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          frame_done;
    logic          busy;
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
    logic          sof_err;
`endif

    filter_window_ctrl #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .KERNEL_SIZE (K)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .out_ready (out_ready),
        .win_valid (win_valid),
        .col       (col),
        .row       (row),
        .frame_done(frame_done),
        .busy      (busy)
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
        ,
        .sof_err   (sof_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int fd_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position kept as a linear pixel index.
    bit m_act, m_done, m_wv, m_serr;
    int m_idx;
    bit m_ready, m_acc;
    bit nx_act, nx_done, nx_wv, nx_serr;
    int nx_idx;

    always_comb begin
        m_ready = !m_done && (!m_wv || out_ready);
        m_acc   = in_valid && m_ready;
        nx_act  = m_act;
        nx_done = 1'b0;
        nx_idx  = m_idx;
        nx_wv   = m_wv && !out_ready;
        nx_serr = 1'b0;
        if (m_done) begin
            nx_act = 1'b0;
        end else if (!m_act) begin
            if (m_acc && in_sof) begin
                nx_act = 1'b1;
                nx_idx = 0;
            end
        end else if (m_acc) begin
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
            if (in_sof) begin
                nx_idx  = 0;
                nx_wv   = 1'b0;
                nx_serr = 1'b1;
            end else
`endif
            begin
                nx_idx = m_idx + 1;
                if ((nx_idx % W) >= K - 1 && (nx_idx / W) >= K - 1) nx_wv = 1'b1;
                if (nx_idx == NPIX - 1) begin
                    nx_act  = 1'b0;
                    nx_done = 1'b1;
                end
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_wv   <= 1'b0;
            m_idx  <= 0;
            m_serr <= 1'b0;
        end else begin
            m_act  <= nx_act;
            m_done <= nx_done;
            m_wv   <= nx_wv;
            m_idx  <= nx_idx;
            m_serr <= nx_serr;
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready",   in_ready,   m_ready);
            chk("shift_en",   shift_en,   m_acc);
            chk("win_valid",  win_valid,  m_wv);
            chk("col",        col,        m_idx % W);
            chk("row",        row,        m_idx / W);
            chk("frame_done", frame_done, m_done);
            chk("busy",       busy,       m_act || m_done);
`ifdef FILTER_WINDOW_CTRL_RESYNC_EN
            chk("sof_err",    sof_err,    m_serr);
`endif
            if (win_valid && out_ready) xfers++;
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame of back-to-back pixels with out_ready high, optionally
    // stalling downstream after pixel stall_pix or resetting after reset_pix.
    task automatic send_frame(input int stall_pix, input int reset_pix);
        xfers  = 0;
        fd_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            tick();
            chk("frame_col", col, i % W);
            chk("frame_row", row, i / W);
            if (i == 17) chk("win_before_first", win_valid, 0);
            if (i == 18) chk("win_first", win_valid, 1);
            if (i == NPIX - 1) chk("frame_done_last", frame_done, 1);
            if (i == stall_pix) begin
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_shift_en", shift_en, 0);
                    chk("stall_win_valid", win_valid, 1);
                    chk("stall_col", col, i % W);
                    chk("stall_row", row, i / W);
                end
                tick();
                out_ready = 1'b1;
            end
            if (i == reset_pix) begin
                reset = 1'b1;
                #1;
                chk("rst_col", col, 0);
                chk("rst_row", row, 0);
                chk("rst_win_valid", win_valid, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_busy", busy, 0);
                in_valid = 1'b0;
                in_sof   = 1'b0;
                tick();
                reset = 1'b0;
                repeat (3) tick();
                chk("rst_no_frame_done", fd_cnt, 0);
                return;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (3) tick();
        chk("frame_windows", xfers, NWIN);
        chk("frame_done_count", fd_cnt, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_col", col, 0);
        chk("reset_row", row, 0);
        chk("reset_win_valid", win_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        tick();

        send_frame(-1, -1);

        // Pixels without in_sof in IDLE are drained but not counted.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            @(negedge clk);
            chk("discard_shift_en", shift_en, 1);
            tick();
            chk("discard_col", col, 0);
            chk("discard_row", row, 0);
            chk("discard_busy", busy, 0);
        end
        in_valid = 1'b0;
        tick();
        send_frame(-1, -1);

        send_frame(20, -1);

        send_frame(-1, 13);
        send_frame(-1, -1);

        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sof    = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filter_window_ctrl.md
FILTER_WINDOW_CTRL -- requirements
Module: filter_window_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3, window edge in pixels (>=2, <=IMAGE_HEIGHT, <=IMAGE_WIDTH).
REQ-004 SHALL have ports (CW=$clog2(IMAGE_WIDTH), RW=$clog2(IMAGE_HEIGHT)):
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  upstream pixel available.
- in_sof  in  1  start-of-frame marker, qualified by in_valid.
- in_ready  out  1  controller accepts pixel this cycle.
- shift_en  out  1  line-buffer/window-register advance strobe.
- out_ready  in  1  downstream accepts window.
- win_valid  out  1  full KxK window present at datapath output.
- col  out  CW  column of the last accepted pixel.
- row  out  RW  row of the last accepted pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement states IDLE, STREAM, DONE.
REQ-006 SHALL define accept = in_valid & in_ready, and drive shift_en = accept combinationally.
REQ-007 in_ready SHALL be 0 in DONE, and otherwise (!win_valid | out_ready).
REQ-008 In IDLE, an accept with in_sof=0 SHALL be discarded: counters unchanged, state unchanged. shift_en still pulses so upstream drains.
REQ-009 In IDLE, an accept with in_sof=1 SHALL load col=0 and row=0 and move to STREAM.
REQ-010 In STREAM, each accept SHALL increment col. At col=IMAGE_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-011 An accept at row=IMAGE_HEIGHT-1, col=IMAGE_WIDTH-1 SHALL move the state to DONE.
REQ-012 DONE SHALL last exactly one cycle, assert frame_done for that cycle, and then return to IDLE.
REQ-013 win_valid SHALL be set in the cycle after an accept whose resulting row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1 (latency 1).
REQ-014 win_valid SHALL hold while out_ready=0, and clear after a cycle with out_ready=1 unless a new qualifying accept occurs in that cycle.
REQ-015 Each frame SHALL yield exactly (IMAGE_WIDTH-KERNEL_SIZE+1)*(IMAGE_HEIGHT-KERNEL_SIZE+1) win_valid/out_ready transfers.
REQ-016 When accept and out_ready=1 coincide, the window SHALL be consumed and the new pixel accepted in the same cycle, with no bubble.
REQ-017 in_sof during STREAM SHALL be ignored unless FILTER_WINDOW_CTRL_RESYNC_EN is defined.

Reset
REQ-018 While reset=1, the block SHALL hold state=IDLE, col=0, row=0, win_valid=0, frame_done=0 and busy=0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame immediately, with no frame_done pulse.
REQ-020 After reset deassertion, the first accepted pixel SHALL require in_sof=1 to start a frame.

Configuration
REQ-021 When FILTER_WINDOW_CTRL_RESYNC_EN is defined:
- an accept with in_sof=1 in STREAM SHALL restart the frame (col=0, row=0), clear win_valid on the next edge, and pulse output sof_err for one cycle.
- The macro SHALL also add port sof_err  out  1, reset value 0.
REQ-022 When the macro is undefined, sof_err SHALL not exist and mid-frame in_sof SHALL have no effect.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=4, KERNEL_SIZE=3)
REQ-023 32 back-to-back pixels, first with in_sof, out_ready=1 -> 12 win_valid cycles, first one cycle after the pixel at row 2/col 2; frame_done pulses once, the cycle after pixel 31.
REQ-024 5 pixels with in_sof=0 in IDLE, then a valid frame -> first 5 pixels discarded, row/col stay 0, frame completes normally.
REQ-025 out_ready=0 for 4 cycles while win_valid=1 -> in_ready=0, shift_en=0, and col/row/win_valid stable until out_ready returns.
REQ-026 Reset pulsed at row 1/col 5 -> all outputs 0 asynchronously, no frame_done; the next in_sof frame produces 12 windows.
REQ-027 With RESYNC_EN defined, in_sof at row 2/col 4 -> sof_err pulse, counters restart at 0, and 12 windows follow before frame_done.
